// File: rtl/act_skew_feeder.sv
// Left-edge activation feeder for the systolic array: accepts one vector per cycle and
// skews lane r by r extra cycles so data enters the array diagonally, then drains and flags tile end.
module act_skew_feeder #(
    parameter int DATASIZE    = 8,
    parameter int ARRAYHEIGHT = 4,
    parameter int COUNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATASIZE*ARRAYHEIGHT-1:0] in_act,
    input  logic                            in_last,
    input  logic                            hold,
    output logic [DATASIZE*ARRAYHEIGHT-1:0] out_left_act,
    output logic [ARRAYHEIGHT-1:0]          out_lane_vld,
    output logic                            busy,
    output logic                            tile_done,
    output logic [COUNT_W-1:0]              vec_count,
    output logic [1:0]                      state_dbg
);

    // Handshake: a vector transfers on a rising edge where in_valid && in_ready.
    // in_ready never looks at in_valid, so the upstream may wait on it freely.

    localparam int DCW = (ARRAYHEIGHT > 1) ? $clog2(ARRAYHEIGHT) : 1;
    localparam logic [DCW-1:0]     DLAST = DCW'(ARRAYHEIGHT - 1);
    localparam logic [COUNT_W-1:0] CMAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [DCW-1:0] dcnt;
    logic           acc;
    logic           drain_done;

    assign in_ready  = ~hold & (state != DRAIN);
    assign acc       = in_valid & in_ready;
    assign tile_done = drain_done;
    assign state_dbg = state;
    assign busy      = (state != IDLE) | (|out_lane_vld);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    state_next = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (acc && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Last lane of the final vector leaves the feeder in this cycle.
                if (dcnt == DLAST) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // dcnt is zero on the first DRAIN cycle because it is held clear outside DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
        end else if (state != DRAIN) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_count <= '0;
        end else if (drain_done) begin
            vec_count <= '0;
        end else if (acc && (vec_count != CMAX)) begin
            vec_count <= vec_count + COUNT_W'(1);
        end
    end

    // Lane r is an (r+1)-deep shift chain; non-accepted cycles inject zero data.
    for (genvar r = 0; r < ARRAYHEIGHT; r++) begin : g_lane
        logic [DATASIZE-1:0] stg_d [r+1];
        logic [r:0]          stg_v;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= r; s++) begin
                    stg_d[s] <= '0;
                end
                stg_v <= '0;
            end else begin
                stg_d[0] <= acc ? in_act[r*DATASIZE +: DATASIZE] : '0;
                stg_v[0] <= acc;
                for (int s = 1; s <= r; s++) begin
                    stg_d[s] <= stg_d[s-1];
                    stg_v[s] <= stg_v[s-1];
                end
            end
        end

        assign out_left_act[r*DATASIZE +: DATASIZE] = stg_d[r];
        assign out_lane_vld[r]                      = stg_v[r];
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: directed vector table, hand sequences for multi-cycle corners,
// and random valid/last/hold traffic checked against a per-cycle history model of the skew.
module tb_act_skew_feeder;

    localparam int H = 4;
    localparam int D = 8;
    localparam int W = H * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_last = 1'b0, hold = 1'b0;
    logic [W-1:0] in_act = '0;
    logic         in_ready, busy, tile_done;
    logic [W-1:0] out_left_act;
    logic [H-1:0] out_lane_vld;
    logic [15:0]  vec_count;
    logic [1:0]   state_dbg;

    logic         c2_ready, c2_busy, c2_done;
    logic [W-1:0] c2_act;
    logic [H-1:0] c2_vld;
    logic [1:0]   c2_cnt, c2_state;

    logic         s_valid = 1'b0, s_last = 1'b0, s_hold = 1'b0;
    logic [D-1:0] s_act = '0;
    logic         s_ready, s_busy, s_done;
    logic [D-1:0] s_out;
    logic [0:0]   s_vld;
    logic [15:0]  s_cnt;
    logic [1:0]   s_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    act_skew_feeder #(.DATASIZE(D), .ARRAYHEIGHT(H), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
        .in_last(in_last), .hold(hold), .out_left_act(out_left_act), .out_lane_vld(out_lane_vld),
        .busy(busy), .tile_done(tile_done), .vec_count(vec_count), .state_dbg(state_dbg)
    );

    act_skew_feeder #(.DATASIZE(D), .ARRAYHEIGHT(H), .COUNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(c2_ready), .in_act(in_act),
        .in_last(in_last), .hold(hold), .out_left_act(c2_act), .out_lane_vld(c2_vld),
        .busy(c2_busy), .tile_done(c2_done), .vec_count(c2_cnt), .state_dbg(c2_state)
    );

    act_skew_feeder #(.DATASIZE(D), .ARRAYHEIGHT(1), .COUNT_W(16)) dut_h1 (
        .clk(clk), .rst(rst_n), .in_valid(s_valid), .in_ready(s_ready), .in_act(s_act),
        .in_last(s_last), .hold(s_hold), .out_left_act(s_out), .out_lane_vld(s_vld),
        .busy(s_busy), .tile_done(s_done), .vec_count(s_cnt), .state_dbg(s_state)
    );

    // Reference model: per-cycle record of what was accepted; outputs are derived from it.
    logic         hv [4096];
    logic         hl [4096];
    logic [W-1:0] hd [4096];
    int cyc  = 0;
    int base = 0;
    int raw  = 0;

    typedef struct {
        logic         v, l, h;
        logic [W-1:0] act;
        logic         e_rdy;
        logic [W-1:0] e_act;
        logic [H-1:0] e_vld;
        logic         e_done;
        logic [15:0]  e_cnt;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic h, input logic [W-1:0] a);
        logic [W-1:0] e_act;
        logic [H-1:0] e_vld;
        logic         e_done, drain, e_rdy;
        int           k;
        @(posedge clk);
        #1;
        in_valid = v; in_last = l; hold = h; in_act = a;
        @(negedge clk);
        e_act = '0; e_vld = '0; e_done = 1'b0; drain = 1'b0;
        for (int r = 0; r < H; r++) begin
            k = cyc - 1 - r;
            if (k >= base && hv[k]) begin
                e_act[r*D +: D] = hd[k][r*D +: D];
                e_vld[r] = 1'b1;
            end
        end
        for (int j = cyc - H; j < cyc; j++) begin
            if (j >= base && hv[j] && hl[j]) begin
                drain = 1'b1;
                if (j == cyc - H) e_done = 1'b1;
            end
        end
        e_rdy = !h && !drain;
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("out_left_act", out_left_act, e_act);
        chk("out_lane_vld", 32'(out_lane_vld), 32'(e_vld));
        chk("tile_done", 32'(tile_done), 32'(e_done));
        chk("busy", 32'(busy), 32'(raw > 0 || e_vld != 0));
        chk("vec_count", 32'(vec_count), 32'((raw > 65535) ? 65535 : raw));
        chk("vec_count_sat2", 32'(c2_cnt), 32'((raw > 3) ? 3 : raw));
        hv[cyc] = v && e_rdy;
        hl[cyc] = l;
        hd[cyc] = a;
        if (e_done) raw = 0;
        if (hv[cyc]) raw++;
        cyc++;
    endtask

    task automatic s_step(input logic v, input logic l, input logic [D-1:0] a, input logic e_rdy,
                          input logic [D-1:0] e_out, input logic e_vld, input logic e_done,
                          input logic [15:0] e_cnt, input logic e_busy);
        @(posedge clk);
        #1;
        s_valid = v; s_last = l; s_act = a;
        @(negedge clk);
        chk("h1_ready", 32'(s_ready), 32'(e_rdy));
        chk("h1_out", 32'(s_out), 32'(e_out));
        chk("h1_vld", 32'(s_vld), 32'(e_vld));
        chk("h1_done", 32'(s_done), 32'(e_done));
        chk("h1_cnt", 32'(s_cnt), 32'(e_cnt));
        chk("h1_busy", 32'(s_busy), 32'(e_busy));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_act"}, out_left_act, 32'h0);
        chk({nm, "_vld"}, 32'(out_lane_vld), 32'h0);
        chk({nm, "_done"}, 32'(tile_done), 32'h0);
        chk({nm, "_cnt"}, 32'(vec_count), 32'h0);
        chk({nm, "_busy"}, 32'(busy), 32'h0);
        chk({nm, "_ready"}, 32'(in_ready), 32'h1);
        chk({nm, "_c2cnt"}, 32'(c2_cnt), 32'h0);
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h04030201, 1'b1, 32'h00000000, 4'h0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h08070605, 1'b1, 32'h00000001, 4'h1, 1'b0, 16'd1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00000205, 4'h3, 1'b0, 16'd2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00030600, 4'h6, 1'b0, 16'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h04070000, 4'hC, 1'b0, 16'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h08000000, 4'h8, 1'b1, 16'd2};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'hDDCCBBAA, 1'b1, 32'h00000000, 4'h0, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000000AA, 4'h1, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000BB00, 4'h2, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00CC0000, 4'h4, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'hDD000000, 4'h8, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00000000, 4'h0, 1'b0, 16'd0};

        // Power-on reset
        #2;
        chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table: two-vector tile then a single-vector tile
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].h, tbl[i].act);
            chk("tbl_ready", 32'(in_ready), 32'(tbl[i].e_rdy));
            chk("tbl_act", out_left_act, tbl[i].e_act);
            chk("tbl_vld", 32'(out_lane_vld), 32'(tbl[i].e_vld));
            chk("tbl_done", 32'(tile_done), 32'(tbl[i].e_done));
            chk("tbl_cnt", 32'(vec_count), 32'(tbl[i].e_cnt));
        end

        // Single-lane instance: drain is one cycle
        s_step(1'b1, 1'b1, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
        s_step(1'b1, 1'b0, 8'h33, 1'b0, 8'h5A, 1'b1, 1'b1, 16'd1, 1'b1);
        s_step(1'b1, 1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
        s_step(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 16'd1, 1'b1);
        s_step(1'b1, 1'b1, 8'h44, 1'b1, 8'h00, 1'b0, 1'b0, 16'd1, 1'b1);
        s_step(1'b0, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 1'b1, 16'd2, 1'b1);
        s_step(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
        base = cyc;

        // Hold for two cycles mid-stream with valid asserted
        step(1'b1, 1'b0, 1'b0, 32'h14131211);
        step(1'b1, 1'b0, 1'b1, 32'h24232221);
        chk("hold_ready0", 32'(in_ready), 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h24232221);
        chk("hold_bubble_lane0", 32'(out_lane_vld[0]), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h24232221);
        chk("hold_bubble_lane0b", 32'(out_lane_vld[0]), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h34333231);
        chk("hold_resume_lane0", out_left_act[7:0], 8'h21);

        // Back-to-back tiles: valid held through the drain
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h44434241);
            if (in_ready) break;
            n++;
        end
        chk("b2b_refused_cycles", 32'(n), 32'(H));
        step(1'b1, 1'b1, 1'b0, 32'h54535251);
        repeat (H + 1) step(1'b0, 1'b0, 1'b0, '0);

        // Counter saturation on the COUNT_W=2 instance
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b1, 1'b0, $urandom);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("sat_c2_cnt", 32'(c2_cnt), 32'd3);
        chk("sat_main_cnt", 32'(vec_count), 32'd5);
        repeat (H) step(1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset in the middle of a drain
        step(1'b1, 1'b0, 1'b0, 32'h64636261);
        step(1'b1, 1'b1, 1'b0, 32'h74737271);
        step(1'b0, 1'b0, 1'b0, '0);
        #2;
        in_valid = 1'b0; in_last = 1'b0; hold = 1'b0; in_act = '0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        raw = 0;
        repeat (H + 2) step(1'b0, 1'b0, 1'b0, '0);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom);
        end
        repeat (H + 2) step(1'b0, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
